// File: rtl/avmm_dual_port_ram_ctl.sv
// -----------------------------------------------------------------------------
// avmm_dual_port_ram_ctl
//   True-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2) on one
//   clock. It is used as a shared parameter/result buffer between the HPS
//   lightweight bridge (s1) and the fabric DSP logic (s2).
//   After reset an optional sweep writes INIT_VALUE to every word. Both ports
//   stall with waitrequest for the whole sweep. Reads are fully pipelined with
//   a latency of READ_LATENCY cycles. Same-address dual writes are resolved
//   per byte lane, and each one increments a saturating counter.
//
// Ports
//   clk, reset_n          single clock, synchronous active-low reset
//   sN_address            word address (N = 1, 2)
//   sN_chipselect         port select
//   sN_read / sN_write    requests; read+write together counts as a write only
//   sN_byteenable         byte lanes for writes
//   sN_writedata          write data
//   sN_readdata           read data, held between readdatavalid pulses
//   sN_readdatavalid      one pulse per accepted read
//   sN_waitrequest        high during reset and during the clear sweep
//   init_done             high once the RAM accepts requests
//   collision_count       saturating count of same-address dual writes
// -----------------------------------------------------------------------------
module avmm_dual_port_ram_ctl #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 2,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
  parameter int                    S1_PRIORITY    = 1,
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    init_done,
  output logic [CNT_WIDTH-1:0]    collision_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BE_W  = DATA_WIDTH / 8;
  // Port index (0 = s1, 1 = s2) that wins lanes enabled by both ports.
  localparam int HI    = (S1_PRIORITY != 0) ? 0 : 1;
  localparam int LO    = 1 - HI;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][BE_W-1:0]       be;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0]                 cs, rd, wr;
  logic [1:0]                 wr_acc, rd_acc;
  logic                       ready;
  logic                       collide;
  logic                       rvld  [2];
  logic [DATA_WIDTH-1:0]      rdata [2];

  assign addr  = {s2_address, s1_address};
  assign be    = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};
  assign cs    = {s2_chipselect, s1_chipselect};
  assign rd    = {s2_read, s1_read};
  assign wr    = {s2_write, s1_write};

  assign ready  = (state_q == ST_READY);
  // Requests are gated with reset_n so nothing lands in the cycle reset is asserted.
  assign wr_acc = {2{reset_n & ready}} & cs & wr;
  assign rd_acc = {2{reset_n & ready}} & cs & rd & ~wr;

  // Stage: control FSM and clear pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_RESET: begin
        ptr_d   = '0;
        state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RESET;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Stage: storage array
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[ptr_q] <= INIT_VALUE;
    end else begin
      for (int b = 0; b < BE_W; b++) begin
        // Low-priority port is written first so the priority port overrides a shared lane.
        if (wr_acc[LO] && be[LO][b]) mem_q[addr[LO]][b*8 +: 8] <= wdata[LO][b*8 +: 8];
        if (wr_acc[HI] && be[HI][b]) mem_q[addr[HI]][b*8 +: 8] <= wdata[HI][b*8 +: 8];
      end
    end
  end

  // Stage: read pipelines (array read happens before the same-edge write lands)
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  vld_p0_q;
    logic [DATA_WIDTH-1:0] dat_p0_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        vld_p0_q <= 1'b0;
        dat_p0_q <= '0;
      end else begin
        vld_p0_q <= rd_acc[p];
        if (rd_acc[p]) dat_p0_q <= mem_q[addr[p]];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic                  vld_p1_q;
      logic [DATA_WIDTH-1:0] dat_p1_q;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          vld_p1_q <= 1'b0;
          dat_p1_q <= '0;
        end else begin
          vld_p1_q <= vld_p0_q;
          if (vld_p0_q) dat_p1_q <= dat_p0_q;
        end
      end

      assign rvld[p]  = vld_p1_q;
      assign rdata[p] = dat_p1_q;
    end else begin : g_lat1
      assign rvld[p]  = vld_p0_q;
      assign rdata[p] = dat_p0_q;
    end
  end

  // Stage: collision counter
  assign collide = wr_acc[0] & wr_acc[1] & (addr[0] == addr[1]) & (|be[0]) & (|be[1]);

  always_comb begin
    cnt_d = cnt_q;
    if (collide && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign s1_readdata      = rdata[0];
  assign s1_readdatavalid = rvld[0];
  assign s1_waitrequest   = ~ready;
  assign s2_readdata      = rdata[1];
  assign s2_readdatavalid = rvld[1];
  assign s2_waitrequest   = ~ready;
  assign init_done        = ready;
  assign collision_count  = cnt_q;

endmodule

// File: tb/tb_avmm_dual_port_ram_ctl.sv
// -----------------------------------------------------------------------------
// Bench for avmm_dual_port_ram_ctl. Two instances share one stimulus stream:
//   dut_a : READ_LATENCY = 1, CNT_WIDTH = 16
//   dut_b : READ_LATENCY = 2, CNT_WIDTH = 4 (saturation is reachable quickly)
// A word-array reference model predicts the outputs of both instances every cycle.
// -----------------------------------------------------------------------------
module tb_avmm_dual_port_ram_ctl;
  localparam int DEPTH = 4;
  localparam int PRIO  = 0;  // s1 wins shared lanes

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
  logic        a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid;
  logic        a_s1_waitrequest, a_s2_waitrequest, b_s1_waitrequest, b_s2_waitrequest;
  logic        a_init_done, b_init_done;
  logic [15:0] a_collision_count;
  logic [3:0]  b_collision_count;

  always #5 clk = ~clk;

  avmm_dual_port_ram_ctl #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0), .S1_PRIORITY(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_readdatavalid),
    .s1_waitrequest(a_s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_readdatavalid),
    .s2_waitrequest(a_s2_waitrequest),
    .init_done(a_init_done), .collision_count(a_collision_count));

  avmm_dual_port_ram_ctl #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0), .S1_PRIORITY(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_readdatavalid),
    .s1_waitrequest(b_s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_readdatavalid),
    .s2_waitrequest(b_s2_waitrequest),
    .init_done(b_init_done), .collision_count(b_collision_count));

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  bit          m_in_reset = 1'b1;
  int          m_busy     = 0;
  int          m_cnt_a    = 0;
  int          m_cnt_b    = 0;
  logic        ea_v [2], eb_v [2], pv [2];
  logic [31:0] ea_d [2], eb_d [2], pd [2];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge of the specification's rules to the model.
  task automatic model_edge();
    logic [1:0]  a  [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic        cs [2], rq [2], wq [2], wa [2], ra [2];
    logic [31:0] rv [2];
    logic        busy, same;
    a[0] = s1_address;    a[1] = s2_address;
    be[0] = s1_byteenable; be[1] = s2_byteenable;
    wd[0] = s1_writedata; wd[1] = s2_writedata;
    cs[0] = s1_chipselect; cs[1] = s2_chipselect;
    rq[0] = s1_read;  rq[1] = s2_read;
    wq[0] = s1_write; wq[1] = s2_write;
    busy = m_in_reset || (m_busy > 0);
    for (int p = 0; p < 2; p++) begin
      wa[p] = reset_n && !busy && cs[p] && wq[p];
      ra[p] = reset_n && !busy && cs[p] && rq[p] && !wq[p];
      rv[p] = mem_m[a[p]];
    end
    if (!m_in_reset && m_busy > 0) begin
      mem_m[DEPTH - m_busy] = 32'h0;
      m_busy--;
    end else begin
      same = wa[0] && wa[1] && (a[0] == a[1]);
      for (int b = 0; b < 4; b++) begin
        if (same && be[0][b] && be[1][b]) begin
          mem_m[a[0]][8*b +: 8] = wd[PRIO][8*b +: 8];
        end else begin
          if (wa[0] && be[0][b]) mem_m[a[0]][8*b +: 8] = wd[0][8*b +: 8];
          if (wa[1] && be[1][b]) mem_m[a[1]][8*b +: 8] = wd[1][8*b +: 8];
        end
      end
      if (same && be[0] != 4'h0 && be[1] != 4'h0) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 15)    m_cnt_b++;
      end
    end
    if (!reset_n) begin
      m_in_reset = 1'b1;
      m_busy  = 0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      for (int p = 0; p < 2; p++) begin
        ea_v[p] = 1'b0; ea_d[p] = 32'h0;
        eb_v[p] = 1'b0; eb_d[p] = 32'h0;
        pv[p]   = 1'b0; pd[p]   = 32'h0;
      end
    end else begin
      if (m_in_reset) begin
        m_in_reset = 1'b0;
        m_busy     = DEPTH;
      end
      for (int p = 0; p < 2; p++) begin
        eb_v[p] = pv[p];
        if (pv[p]) eb_d[p] = pd[p];
        pv[p] = ra[p];
        pd[p] = rv[p];
        ea_v[p] = ra[p];
        if (ra[p]) ea_d[p] = rv[p];
      end
    end
  endtask

  task automatic check_all();
    logic ew;
    ew = m_in_reset || (m_busy > 0);
    chk("A.s1_waitrequest", 32'(a_s1_waitrequest), 32'(ew));
    chk("A.s2_waitrequest", 32'(a_s2_waitrequest), 32'(ew));
    chk("A.init_done", 32'(a_init_done), 32'(!ew));
    chk("A.s1_readdatavalid", 32'(a_s1_readdatavalid), 32'(ea_v[0]));
    chk("A.s2_readdatavalid", 32'(a_s2_readdatavalid), 32'(ea_v[1]));
    chk("A.s1_readdata", a_s1_readdata, ea_d[0]);
    chk("A.s2_readdata", a_s2_readdata, ea_d[1]);
    chk("A.collision_count", 32'(a_collision_count), 32'(m_cnt_a));
    chk("B.s1_waitrequest", 32'(b_s1_waitrequest), 32'(ew));
    chk("B.s2_waitrequest", 32'(b_s2_waitrequest), 32'(ew));
    chk("B.init_done", 32'(b_init_done), 32'(!ew));
    chk("B.s1_readdatavalid", 32'(b_s1_readdatavalid), 32'(eb_v[0]));
    chk("B.s2_readdatavalid", 32'(b_s2_readdatavalid), 32'(eb_v[1]));
    chk("B.s1_readdata", b_s1_readdata, eb_d[0]);
    chk("B.s2_readdata", b_s2_readdata, eb_d[1]);
    chk("B.collision_count", 32'(b_collision_count), 32'(m_cnt_b));
  endtask

  task automatic p1(input logic r, input logic w, input logic [1:0] a,
                    input logic [3:0] be, input logic [31:0] d);
    s1_chipselect = r | w; s1_read = r; s1_write = w;
    s1_address = a; s1_byteenable = be; s1_writedata = d;
  endtask

  task automatic p2(input logic r, input logic w, input logic [1:0] a,
                    input logic [3:0] be, input logic [31:0] d);
    s2_chipselect = r | w; s2_read = r; s2_write = w;
    s2_address = a; s2_byteenable = be; s2_writedata = d;
  endtask

  // One clock: model the edge, sample 1 time unit later, then release both ports.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    p1(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    p2(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] r;
    p1(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    p2(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);

    // Reset for two cycles.
    reset_n = 1'b0;
    tick();
    tick();
    chk("reset.init_done", 32'(a_init_done), 32'd0);
    chk("reset.waitrequest", 32'(a_s1_waitrequest), 32'd1);

    // Clear sweep: requests driven meanwhile must be ignored.
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      p1(1'b0, 1'b1, 2'd0, 4'hF, 32'hFFFF_FFFF);
      p2(1'b0, 1'b1, 2'd3, 4'hF, 32'hEEEE_EEEE);
      tick();
      if (a_s1_waitrequest) n++;
      else break;
    end
    chk("clear.wait_cycles", 32'(n), 32'd4);
    chk("clear.init_done", 32'(a_init_done), 32'd1);

    // All words read back as the clear value.
    for (int i = 0; i < 4; i++) begin
      p1(1'b1, 1'b0, 2'(i), 4'h0, 32'h0);
      p2(1'b1, 1'b0, 2'(3 - i), 4'h0, 32'h0);
      tick();
      chk("clear.s1_word_zero", a_s1_readdata, 32'h0);
      chk("clear.s1_valid", 32'(a_s1_readdatavalid), 32'd1);
    end
    tick();
    tick();

    // Byte-lane write.
    p1(1'b0, 1'b1, 2'd1, 4'hF, 32'hAABB_CCDD); tick();
    p1(1'b0, 1'b1, 2'd1, 4'h5, 32'h1122_3344); tick();
    p2(1'b1, 1'b0, 2'd1, 4'h0, 32'h0);         tick();
    chk("lane.A_s2_readdata", a_s2_readdata, 32'hAA22_CC44);
    tick();
    chk("lane.B_s2_readdata", b_s2_readdata, 32'hAA22_CC44);

    // Back-to-back pipelined reads on s2.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) p2(1'b1, 1'b0, 2'(i), 4'h0, 32'h0);
      tick();
      if (i == 0) chk("pipe.B_not_yet_valid", 32'(b_s2_readdatavalid), 32'd0);
      if (b_s2_readdatavalid) n++;
    end
    chk("pipe.B_pulse_count", 32'(n), 32'd4);

    // Same-address collision, s1 priority.
    p1(1'b0, 1'b1, 2'd2, 4'h3, 32'h1111_1111);
    p2(1'b0, 1'b1, 2'd2, 4'hE, 32'h2222_2222);
    tick();
    chk("coll.count", 32'(a_collision_count), 32'd1);
    p1(1'b1, 1'b0, 2'd2, 4'h0, 32'h0); tick();
    chk("coll.word", a_s1_readdata, 32'h2222_1111);

    // Read-during-write returns old data.
    p1(1'b0, 1'b1, 2'd3, 4'hF, 32'hDEAD_BEEF);
    p2(1'b1, 1'b0, 2'd3, 4'h0, 32'h0);
    tick();
    chk("rdw.old_data", a_s2_readdata, 32'h0);
    p2(1'b1, 1'b0, 2'd3, 4'h0, 32'h0); tick();
    chk("rdw.new_data", a_s2_readdata, 32'hDEAD_BEEF);

    // Read+write on one port is a write only; byteenable 0 changes nothing.
    p1(1'b1, 1'b1, 2'd0, 4'hF, 32'h1234_5678); tick();
    chk("rw.no_valid", 32'(a_s1_readdatavalid), 32'd0);
    p1(1'b0, 1'b1, 2'd0, 4'h0, 32'hFFFF_FFFF);
    p2(1'b0, 1'b1, 2'd0, 4'h0, 32'hFFFF_FFFF);
    tick();
    chk("be0.no_count", 32'(a_collision_count), 32'd1);
    p1(1'b1, 1'b0, 2'd0, 4'h0, 32'h0); tick();
    chk("be0.word", a_s1_readdata, 32'h1234_5678);

    // Randomized traffic on both ports.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      p1(r[0], r[1], r[3:2], r[7:4], $urandom);
      p2(r[8], r[9], r[11:10], r[15:12], $urandom);
      tick();
    end

    // Drive the narrow counter into saturation.
    for (int i = 0; i < 16; i++) begin
      p1(1'b0, 1'b1, 2'd1, 4'h1, $urandom);
      p2(1'b0, 1'b1, 2'd1, 4'h8, $urandom);
      tick();
    end
    chk("sat.B_count", 32'(b_collision_count), 32'hF);

    // Reset pulsed at sweep cycle 2 restarts the sweep.
    reset_n = 1'b0; tick();
    reset_n = 1'b1; tick(); tick(); tick();
    reset_n = 1'b0; tick();
    chk("midclr.count_cleared", 32'(a_collision_count), 32'd0);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_s1_waitrequest) n++;
      else break;
    end
    chk("midclr.wait_cycles", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      p1(1'b1, 1'b0, 2'(i), 4'h0, 32'h0);
      tick();
      chk("midclr.word_zero", a_s1_readdata, 32'h0);
    end
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avmm_dual_port_ram_ctl.md
Name: avmm_dual_port_ram_ctl

Overview:
- Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports, s1 and s2, on a single clock.
- Successor to the fixed 4-word x 32-bit dual-port RAM.
- Adds configurable width and depth, pipelined reads with readdatavalid, and a post-reset clear sweep signalled by waitrequest.
- Adds deterministic same-address collision resolution with a saturating collision counter.
- Sits between the HPS lightweight bridge (s1) and fabric DSP logic (s2) as a shared parameter/result buffer.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 2, word address width; DEPTH = 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = write INIT_VALUE to every word after reset; 0 = contents retained.
- INIT_VALUE, 0, word written during the clear sweep.
- S1_PRIORITY, 1, 1 = s1 wins same-address byte-lane write collisions; 0 = s2 wins.
- CNT_WIDTH, 16, width of collision_count.

Ports:
- clk  in  1  single clock for both ports
- reset_n  in  1  synchronous reset, active low
- s1_address  in  ADDR_WIDTH  port 1 word address
- s1_chipselect  in  1  port 1 select
- s1_read  in  1  port 1 read request
- s1_write  in  1  port 1 write request
- s1_byteenable  in  DATA_WIDTH/8  port 1 byte lanes
- s1_writedata  in  DATA_WIDTH  port 1 write data
- s1_readdata  out  DATA_WIDTH  port 1 read data
- s1_readdatavalid  out  1  port 1 read data valid pulse
- s1_waitrequest  out  1  port 1 stall
- s2_*  same set as s1_*, for port 2
- init_done  out  1  high once the RAM is ready
- collision_count  out  CNT_WIDTH  saturating count of same-address dual writes

Behaviour:
- Reset: synchronous to clk, active low.
  - While reset_n = 0: readdata = 0, readdatavalid = 0, waitrequest = 1, init_done = 0, collision_count = 0, clear pointer = 0, read pipelines flushed.
- FSM states: RESET -> CLEAR -> READY.
  - RESET exits on the first clk with reset_n = 1.
  - CLEAR_ON_RESET = 0: RESET goes directly to READY.
- CLEAR state:
  - Writes INIT_VALUE to word[ptr] each cycle; ptr increments 0..DEPTH-1.
  - Lasts exactly DEPTH cycles; transitions to READY after ptr = DEPTH-1.
  - waitrequest = 1 on both ports; all requests are ignored and must be held by the master.
  - reset_n low mid-sweep restarts the sweep at ptr = 0.
- READY state:
  - waitrequest = 0 permanently; init_done = 1.
- Accepted write: chipselect & write & !waitrequest.
  - Updates only the lanes enabled by byteenable.
  - byteenable = 0 is accepted and changes nothing.
- Accepted read: chipselect & read & !write & !waitrequest.
  - Fully pipelined: one read per port per cycle.
  - readdatavalid pulses for one cycle exactly READY_LATENCY... READ_LATENCY cycles after acceptance.
  - readdata holds its last value while readdatavalid = 0.
- read & write in the same cycle on one port: treated as a write only; no readdatavalid.
- Read-during-write, same address (same or opposite port): read returns the old data (read-before-write).
- Dual write, same address, same cycle:
  - Lanes enabled by only one port take that port's data.
  - Lanes enabled by both ports take the priority port's data.
  - collision_count += 1 when both byteenables are nonzero; saturates at all-ones, no wrap.
- Dual write to different addresses: both complete, no count.
- Addresses wrap naturally; there is no out-of-range address.
- Every accepted read produces exactly one readdatavalid; no request is lost or duplicated.

Test Plan:
- Reset sequence: reset_n low 2 cycles, then high -> waitrequest high for exactly 4 cycles, init_done rises on cycle 5; reads of words 0..3 return 0x00000000 with readdatavalid 1 cycle after acceptance.
- Byte-lane write: s1 writes 0xAABBCCDD to addr 1 with byteenable 0xF, then 0x11223344 with byteenable 0x5 -> s2 reads addr 1 = 0xAA22CC44.
- Back-to-back pipelined reads, READ_LATENCY = 2: s2 reads addr 0,1,2,3 on consecutive cycles -> four consecutive readdatavalid pulses, starting 2 cycles after the first request, with data in address order.
- Collision, S1_PRIORITY = 1: s1 writes 0x11111111 with byteenable 0x3 and s2 writes 0x22222222 with byteenable 0xE, both to addr 2 -> word = 0x22221111; collision_count = 1.
- Read-during-write: s1 writes 0xDEADBEEF to addr 3 while s2 reads addr 3 in the same cycle (old value 0) -> s2 receives 0x00000000; the next read of addr 3 returns 0xDEADBEEF.
- Reset mid-clear, DEPTH = 4: pulse reset_n low at sweep cycle 2 -> sweep restarts, waitrequest high for a further 4 cycles; collision_count forced to 0xFFFF then one more collision -> stays 0xFFFF.
